// File: rtl/fir_interp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fir_interp
// Brief    : Polyphase interpolating FIR. Pops one sample from an upstream
//            FWFT FIFO and pushes INTERP_FACTOR filtered samples downstream.
//            Taps are Q.FRAC_BITS; each product is floor-shifted before it is
//            summed and the sum wraps modulo 2^DATA_WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module fir_interp #(
    parameter int TAP_COUNT      = 32,
    parameter int INTERP_FACTOR  = 4,
    parameter int MULT_PER_CYCLE = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int FRAC_BITS      = 10,
    parameter logic [0:TAP_COUNT-1][DATA_WIDTH-1:0] TAPS = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic                  busy
);

    localparam int PHASE_TAPS  = TAP_COUNT / INTERP_FACTOR;
    localparam int CALC_CYCLES = PHASE_TAPS / MULT_PER_CYCLE;
    localparam int PHASE_W     = (INTERP_FACTOR > 1) ? $clog2(INTERP_FACTOR) : 1;
    localparam int TAPCNT_W    = (CALC_CYCLES > 1)   ? $clog2(CALC_CYCLES)   : 1;
    localparam int TIDX_W      = (TAP_COUNT > 1)     ? $clog2(TAP_COUNT)     : 1;
    localparam int HIDX_W      = (PHASE_TAPS > 1)    ? $clog2(PHASE_TAPS)    : 1;

    localparam logic [PHASE_W-1:0]  LAST_PHASE  = PHASE_W'(INTERP_FACTOR - 1);
    localparam logic [TAPCNT_W-1:0] LAST_TAPCNT = TAPCNT_W'(CALC_CYCLES - 1);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] h_q [0:PHASE_TAPS-1];
    logic [DATA_WIDTH-1:0] h_d [0:PHASE_TAPS-1];
    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic [TAPCNT_W-1:0]   tapcnt_q, tapcnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] out_din_q, out_din_d;

    logic [DATA_WIDTH-1:0]          sum;
    logic [TIDX_W-1:0]              tidx;
    logic [HIDX_W-1:0]              hidx;
    logic [DATA_WIDTH-1:0]          coef;
    logic [DATA_WIDTH-1:0]          samp;
    logic signed [2*DATA_WIDTH-1:0] prod;

    // Partial sum of this cycle's MULT_PER_CYCLE dequantized products for the current phase
    always_comb begin
        sum  = '0;
        tidx = '0;
        hidx = '0;
        coef = '0;
        samp = '0;
        prod = '0;
        for (int m = 0; m < MULT_PER_CYCLE; m++) begin
            hidx = HIDX_W'(int'(tapcnt_q) * MULT_PER_CYCLE + m);
            tidx = TIDX_W'((int'(tapcnt_q) * MULT_PER_CYCLE + m) * INTERP_FACTOR + int'(phase_q));
            coef = TAPS[tidx];
            samp = h_q[hidx];
            // Sign-extend both operands so the low 2*DATA_WIDTH bits are the signed product
            prod = {{DATA_WIDTH{coef[DATA_WIDTH-1]}}, coef} * {{DATA_WIDTH{samp[DATA_WIDTH-1]}}, samp};
            sum  = sum + DATA_WIDTH'(prod >>> FRAC_BITS);
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (!in_empty) state_d = S_CALC;
            S_CALC:  if (tapcnt_q == LAST_TAPCNT) state_d = S_WRITE;
            S_WRITE: if (!out_full) state_d = (phase_q == LAST_PHASE) ? S_FETCH : S_CALC;
            default: state_d = S_FETCH;
        endcase
    end

    // Handshake outputs; the pop is masked while reset is held so nothing is lost
    always_comb begin
        in_rd_en  = reset && (state_q == S_FETCH) && !in_empty;
        out_wr_en = (state_q == S_WRITE) && !out_full;
        busy      = (state_q != S_FETCH);
    end

    // Datapath next values: history shift, phase/tap stepping, accumulation
    always_comb begin
        h_d       = h_q;
        phase_d   = phase_q;
        tapcnt_d  = tapcnt_q;
        acc_d     = acc_q;
        out_din_d = out_din_q;
        case (state_q)
            S_FETCH: begin
                if (!in_empty) begin
                    h_d[0] = in_dout;
                    for (int k = 1; k < PHASE_TAPS; k++) h_d[k] = h_q[k-1];
                    phase_d  = '0;
                    tapcnt_d = '0;
                    acc_d    = '0;
                end
            end
            S_CALC: begin
                acc_d = acc_q + sum;
                if (tapcnt_q == LAST_TAPCNT) out_din_d = acc_q + sum;
                else                         tapcnt_d  = tapcnt_q + TAPCNT_W'(1);
            end
            S_WRITE: begin
                // The last phase wraps back to 0 only through FETCH
                if (!out_full && (phase_q != LAST_PHASE)) begin
                    phase_d  = phase_q + PHASE_W'(1);
                    tapcnt_d = '0;
                    acc_d    = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h_q       <= '{default: '0};
            phase_q   <= '0;
            tapcnt_q  <= '0;
            acc_q     <= '0;
            out_din_q <= '0;
        end else begin
            h_q       <= h_d;
            phase_q   <= phase_d;
            tapcnt_q  <= tapcnt_d;
            acc_q     <= acc_d;
            out_din_q <= out_din_d;
        end
    end

    assign out_din = out_din_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_interp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fir_interp
// Brief    : Self-checking bench for fir_interp (8 taps, 4 phases). Four DUTs
//            with different tap sets share clock and reset; one is exercised
//            at a time against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_interp;

    localparam int L = 4;
    localparam int P = 2;

    localparam logic [0:7][31:0] T0 = {8{32'd1024}};
    localparam logic [0:7][31:0] T1 = {32'd1024, 32'd2048, 32'd3072, 32'd4096,
                                       32'd0, 32'd0, 32'd0, 32'd0};
    localparam logic [0:7][31:0] T2 = {8{32'd512}};
    localparam logic [0:7][31:0] T3 = {32'(-1536), 32'd700, 32'd3000, 32'(-2048),
                                       32'd1, 32'(-1023), 32'd5000, 32'd333};

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_dout_v   [4];
    logic        in_empty_v  [4];
    logic        in_rd_en_v  [4];
    logic [31:0] out_din_v   [4];
    logic        out_full_v  [4];
    logic        out_wr_en_v [4];
    logic        busy_v      [4];

    logic [31:0] inq[$];
    logic [31:0] got[$];
    logic [31:0] expq[$];
    logic [31:0] hist[$];
    int          pop_cyc[$];
    int          wr_cyc[$];
    int          viol;
    int          cyc;
    int          nvec;
    int          nerr;

    always #5 clock = ~clock;

    fir_interp #(.TAP_COUNT(8), .INTERP_FACTOR(4), .MULT_PER_CYCLE(1), .DATA_WIDTH(32),
                 .FRAC_BITS(10), .TAPS(T0)) u_dut0 (
        .clock(clock), .reset(reset), .in_dout(in_dout_v[0]), .in_empty(in_empty_v[0]),
        .in_rd_en(in_rd_en_v[0]), .out_din(out_din_v[0]), .out_full(out_full_v[0]),
        .out_wr_en(out_wr_en_v[0]), .busy(busy_v[0]));
    fir_interp #(.TAP_COUNT(8), .INTERP_FACTOR(4), .MULT_PER_CYCLE(1), .DATA_WIDTH(32),
                 .FRAC_BITS(10), .TAPS(T1)) u_dut1 (
        .clock(clock), .reset(reset), .in_dout(in_dout_v[1]), .in_empty(in_empty_v[1]),
        .in_rd_en(in_rd_en_v[1]), .out_din(out_din_v[1]), .out_full(out_full_v[1]),
        .out_wr_en(out_wr_en_v[1]), .busy(busy_v[1]));
    fir_interp #(.TAP_COUNT(8), .INTERP_FACTOR(4), .MULT_PER_CYCLE(1), .DATA_WIDTH(32),
                 .FRAC_BITS(10), .TAPS(T2)) u_dut2 (
        .clock(clock), .reset(reset), .in_dout(in_dout_v[2]), .in_empty(in_empty_v[2]),
        .in_rd_en(in_rd_en_v[2]), .out_din(out_din_v[2]), .out_full(out_full_v[2]),
        .out_wr_en(out_wr_en_v[2]), .busy(busy_v[2]));
    fir_interp #(.TAP_COUNT(8), .INTERP_FACTOR(4), .MULT_PER_CYCLE(2), .DATA_WIDTH(32),
                 .FRAC_BITS(10), .TAPS(T3)) u_dut3 (
        .clock(clock), .reset(reset), .in_dout(in_dout_v[3]), .in_empty(in_empty_v[3]),
        .in_rd_en(in_rd_en_v[3]), .out_din(out_din_v[3]), .out_full(out_full_v[3]),
        .out_wr_en(out_wr_en_v[3]), .busy(busy_v[3]));

    function automatic logic [31:0] tap_of(input int d, input int i);
        case (d)
            0:       return T0[i];
            1:       return T1[i];
            2:       return T2[i];
            default: return T3[i];
        endcase
    endfunction

    // Reference: y_p = sum_k floor(tap[k*L+p] * h[k] / 2^10), wrapped to 32 bits
    function automatic void model_push(input int d, input logic [31:0] x);
        logic [31:0] acc;
        longint      prod;
        hist.push_front(x);
        while (hist.size() > P) void'(hist.pop_back());
        for (int p = 0; p < L; p++) begin
            acc = 32'd0;
            for (int k = 0; k < P; k++) begin
                prod = longint'(int'(tap_of(d, k*L + p))) * longint'(int'(hist[k]));
                acc  = acc + 32'(prod >>> 10);
            end
            expq.push_back(acc);
        end
    endfunction

    task automatic push(input int d, input logic [31:0] x);
        inq.push_back(x);
        model_push(d, x);
    endtask

    task automatic idle_all();
        for (int i = 0; i < 4; i++) begin
            in_empty_v[i]  = 1'b1;
            in_dout_v[i]   = 32'd0;
            out_full_v[i]  = 1'b0;
        end
    endtask

    task automatic clear_model();
        inq.delete(); got.delete(); expq.delete(); pop_cyc.delete(); wr_cyc.delete();
        hist = '{32'd0, 32'd0};
        viol = 0;
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1'b0;
        clear_model();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        cyc = 0;
    endtask

    // One clock cycle on DUT d: drive at the negedge, observe 1ns later, log handshakes
    task automatic cycle(input int d, input bit full, input bit hold_empty,
                         output logic rd, output logic wr, output logic [31:0] dout,
                         output logic bsy);
        idle_all();
        in_empty_v[d] = hold_empty || (inq.size() == 0);
        in_dout_v[d]  = (inq.size() != 0) ? inq[0] : $urandom;
        out_full_v[d] = full;
        #1;
        rd   = in_rd_en_v[d];
        wr   = out_wr_en_v[d];
        dout = out_din_v[d];
        bsy  = busy_v[d];
        if (rd === 1'b1 && wr === 1'b1) viol++;
        if (rd === 1'b1 && in_empty_v[d]) viol++;
        if (wr === 1'b1 && out_full_v[d]) viol++;
        if (wr === 1'b1) begin got.push_back(dout); wr_cyc.push_back(cyc); end
        if (rd === 1'b1) begin
            if (inq.size() != 0) void'(inq.pop_front());
            pop_cyc.push_back(cyc);
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic run(input int d, input int nw, input int budget, input int full_pct,
                       input int empty_pct, output bit ok);
        logic rd, wr, bsy;
        logic [31:0] dout;
        int n;
        n = 0;
        while (got.size() < nw && n < budget) begin
            cycle(d, $urandom_range(99) < full_pct, $urandom_range(99) < empty_pct,
                  rd, wr, dout, bsy);
            n++;
        end
        ok = (got.size() >= nw);
    endtask

    task automatic idle_cycles(input int d, input int n);
        logic rd, wr, bsy;
        logic [31:0] dout;
        repeat (n) cycle(d, 1'b0, 1'b0, rd, wr, dout, bsy);
    endtask

    task automatic test_reset();
        idle_all();
        reset = 1'b0;
        in_empty_v[0] = 1'b0;
        in_dout_v[0]  = 32'd55;
        repeat (2) @(negedge clock);
        #1;
        nvec++;
        if (in_rd_en_v[0] !== 1'b0) begin
            nerr++; $display("FAIL reset_rd_en: got %b expected 0", in_rd_en_v[0]);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (out_din_v[i] !== 32'd0 || out_wr_en_v[i] !== 1'b0 || busy_v[i] !== 1'b0) begin
                nerr++;
                $display("FAIL reset_state[%0d]: got din=%h wr=%b busy=%b expected 0/0/0",
                         i, out_din_v[i], out_wr_en_v[i], busy_v[i]);
            end
        end
    endtask

    task automatic test_all_ones();
        bit ok;
        do_reset();
        push(0, 32'd5);
        push(0, 32'd7);
        run(0, 8, 200, 0, 0, ok);
        idle_cycles(0, 15);
        nvec++;
        if (!ok || got.size() != 8) begin
            nerr++; $display("FAIL ones_count: got %0d writes expected 8", got.size());
        end
        for (int i = 0; i < expq.size(); i++) begin
            nvec++;
            if (i >= got.size() || got[i] !== expq[i]) begin
                nerr++;
                $display("FAIL ones_out[%0d]: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 32'hx, expq[i]);
            end
        end
        nvec++;
        if (got.size() != 8 || got[0] !== 32'd5 || got[7] !== 32'd12) begin
            nerr++; $display("FAIL ones_values: first/last got %h/%h expected 5/12",
                             (got.size() > 0) ? got[0] : 32'hx, (got.size() > 7) ? got[7] : 32'hx);
        end
        nvec++;
        if (viol !== 0) begin nerr++; $display("FAIL ones_protocol: got %0d violations expected 0", viol); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        push(0, 32'd3);
        push(0, 32'd9);
        run(0, 8, 200, 0, 0, ok);
        nvec++;
        if (!ok || pop_cyc.size() < 2 || wr_cyc.size() < 1) begin
            nerr++; $display("FAIL b2b_run: got %0d pops %0d writes expected 2/8", pop_cyc.size(), wr_cyc.size());
        end else begin
            nvec++;
            if (wr_cyc[0] - pop_cyc[0] !== 3) begin
                nerr++; $display("FAIL b2b_latency: got %0d cycles expected 3", wr_cyc[0] - pop_cyc[0]);
            end
            nvec++;
            if (pop_cyc[1] - pop_cyc[0] !== 13) begin
                nerr++; $display("FAIL b2b_throughput: got %0d cycles expected 13", pop_cyc[1] - pop_cyc[0]);
            end
        end
    endtask

    task automatic test_phase_order();
        bit ok;
        do_reset();
        push(1, 32'd100);
        run(1, 4, 100, 0, 0, ok);
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (i >= got.size() || got[i] !== 32'(100 * (i + 1)) || got[i] !== expq[i]) begin
                nerr++;
                $display("FAIL phase_out[%0d]: got %h expected %0d", i,
                         (i < got.size()) ? got[i] : 32'hx, 100 * (i + 1));
            end
        end
    endtask

    task automatic test_floor_shift();
        bit ok;
        do_reset();
        push(2, 32'hFFFF_FFFD);
        run(2, 4, 100, 0, 0, ok);
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (i >= got.size() || got[i] !== 32'hFFFF_FFFE || got[i] !== expq[i]) begin
                nerr++;
                $display("FAIL floor_out[%0d]: got %h expected fffffffe", i,
                         (i < got.size()) ? got[i] : 32'hx);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic rd, wr, bsy;
        logic [31:0] dout;
        do_reset();
        push(0, 32'd5);
        push(0, 32'd7);
        run(0, 1, 100, 0, 0, ok);
        // Two CALC cycles, then ten cycles parked in the second WRITE
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1'b1, 1'b0, rd, wr, dout, bsy);
            nvec++;
            if (wr !== 1'b0) begin nerr++; $display("FAIL bp_wr_en[%0d]: got %b expected 0", i, wr); end
            if (i >= 2) begin
                nvec++;
                if (dout !== expq[1] || bsy !== 1'b1) begin
                    nerr++; $display("FAIL bp_hold[%0d]: got din=%h busy=%b expected %h/1", i, dout, bsy, expq[1]);
                end
            end
        end
        run(0, 8, 200, 0, 0, ok);
        idle_cycles(0, 10);
        nvec++;
        if (got.size() != 8) begin nerr++; $display("FAIL bp_count: got %0d expected 8", got.size()); end
        for (int i = 0; i < expq.size(); i++) begin
            nvec++;
            if (i >= got.size() || got[i] !== expq[i]) begin
                nerr++;
                $display("FAIL bp_out[%0d]: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 32'hx, expq[i]);
            end
        end
        nvec++;
        if (viol !== 0) begin nerr++; $display("FAIL bp_protocol: got %0d violations expected 0", viol); end
    endtask

    task automatic test_empty_hold();
        bit ok;
        logic rd, wr, bsy;
        logic [31:0] dout;
        do_reset();
        push(0, 32'd9);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1'b0, 1'b1, rd, wr, dout, bsy);
            nvec++;
            if (rd !== 1'b0 || bsy !== 1'b0 || wr !== 1'b0) begin
                nerr++; $display("FAIL empty_idle[%0d]: got rd=%b busy=%b wr=%b expected 0/0/0", i, rd, bsy, wr);
            end
        end
        run(0, 4, 100, 0, 0, ok);
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (i >= got.size() || got[i] !== expq[i]) begin
                nerr++;
                $display("FAIL empty_out[%0d]: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 32'hx, expq[i]);
            end
        end
    endtask

    task automatic test_reset_midcalc();
        bit ok;
        do_reset();
        push(0, 32'd3);
        push(0, 32'd5);
        run(0, 6, 200, 0, 0, ok);
        // Phases 0 and 1 of the second sample are out; the DUT is now in CALC of phase 2
        nvec++;
        if (!ok || busy_v[0] !== 1'b1) begin
            nerr++; $display("FAIL midcalc_pre: got busy=%b writes=%0d expected 1/6", busy_v[0], got.size());
        end
        #2 reset = 1'b0;
        #1;
        nvec++;
        if (out_din_v[0] !== 32'd0 || busy_v[0] !== 1'b0 || out_wr_en_v[0] !== 1'b0 || in_rd_en_v[0] !== 1'b0) begin
            nerr++;
            $display("FAIL midcalc_reset: got din=%h busy=%b wr=%b rd=%b expected 0/0/0/0",
                     out_din_v[0], busy_v[0], out_wr_en_v[0], in_rd_en_v[0]);
        end
        repeat (2) @(negedge clock);
        clear_model();
        reset = 1'b1;
        push(0, 32'd7);
        run(0, 4, 100, 0, 0, ok);
        idle_cycles(0, 10);
        nvec++;
        if (got.size() != 4) begin nerr++; $display("FAIL midcalc_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (i >= got.size() || got[i] !== 32'd7 || got[i] !== expq[i]) begin
                nerr++;
                $display("FAIL midcalc_out[%0d]: got %h expected 7", i, (i < got.size()) ? got[i] : 32'hx);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] x;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            if (i % 2 == 0) x = 32'(int'(x[20:0]) - (1 << 20));
            push(3, x);
        end
        run(3, 160, 20000, 30, 30, ok);
        idle_cycles(3, 20);
        nvec++;
        if (!ok || got.size() != 160) begin
            nerr++; $display("FAIL rand_count: got %0d expected 160", got.size());
        end
        for (int i = 0; i < expq.size(); i++) begin
            nvec++;
            if (i >= got.size() || got[i] !== expq[i]) begin
                nerr++;
                $display("FAIL rand_out[%0d]: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 32'hx, expq[i]);
            end
        end
        nvec++;
        if (viol !== 0) begin nerr++; $display("FAIL rand_protocol: got %0d violations expected 0", viol); end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        cyc  = 0;
        viol = 0;
        idle_all();
        test_reset();
        test_all_ones();
        test_back_to_back();
        test_phase_order();
        test_floor_shift();
        test_backpressure();
        test_empty_hold();
        test_reset_midcalc();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
